countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Consumer of the one-cycle `secPassed` tick produced by the frame-based seconds clock.
- Holds the game's remaining time, counts it down once per tick and exposes it as BCD digits (M:SS) for the score/HUD renderer.
- Raises `timeUp` once when time runs out.
- Supports bonus-time injection, restart and pause.

Parameters:
- START_SECONDS, 120, value loaded on reset and on `start`; legal range 1..599.
- BONUS_SECONDS, 10, seconds added per `addTime` pulse; legal range 1..599.
- WARN_SECONDS, 10, `lowTime` asserts when remaining time is 1..WARN_SECONDS.

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-low reset, sampled on rising clk
- secPassed  in  1  one-cycle pulse, once per second
- start  in  1  one-cycle pulse: (re)load START_SECONDS and run
- pause  in  1  level; while high, ticks are ignored
- addTime  in  1  one-cycle pulse: add BONUS_SECONDS
- minutes  out  4  BCD minutes digit, 0..9
- secTens  out  4  BCD tens-of-seconds digit, 0..5
- secOnes  out  4  BCD seconds digit, 0..9
- running  out  1  high in RUNNING state
- lowTime  out  1  remaining time in 1..WARN_SECONDS and state RUNNING or PAUSED
- timeUp  out  1  one-cycle pulse on expiry
- blinkOn  out  1  display-enable for HUD digits (see Optional Feature)

Behaviour:
- Internal binary counter `remain`, 10 bits, range 0..599.
- Digits are combinational from `remain`: minutes=remain/60, secTens=(remain%60)/10, secOnes=remain%10. Zero-cycle latency from counter to digits.
- Reset (resetN=0 at posedge):
  - state=IDLE, remain=START_SECONDS.
  - timeUp=0, running=0, lowTime=0, blinkOn=1.
- States: IDLE, RUNNING, PAUSED, EXPIRED.
  - IDLE: `start` -> RUNNING with remain=START_SECONDS. `secPassed` and `addTime` are ignored.
  - RUNNING:
    - `pause`=1 -> PAUSED; the tick in that cycle is ignored.
    - `secPassed` -> remain-1.
    - If the resulting remain==0 -> EXPIRED, and timeUp=1 for exactly the following cycle (registered with the transition).
  - PAUSED: `pause`=0 -> RUNNING. Ticks are ignored; `addTime` is honoured.
  - EXPIRED:
    - remain stays 0; `addTime` is ignored.
    - `start` -> RUNNING with reload.
- `start` has the highest priority in every state:
  - reload and go RUNNING; a simultaneous `secPassed`/`addTime` is discarded.
  - if `pause`=1 in the same cycle, go PAUSED after reload.
- `addTime` in RUNNING/PAUSED: remain = min(remain+BONUS_SECONDS, 599).
- `addTime` together with `secPassed` in RUNNING: remain = min(remain+BONUS_SECONDS, 599) - 1.
  - At remain==1 this yields BONUS_SECONDS, with no expiry and no timeUp.
  - Saturation is applied before the decrement.
- timeUp fires only on a RUNNING->EXPIRED transition; it never fires twice without an intervening `start`.
- Synchronous reset mid-run aborts immediately: the next cycle shows START_SECONDS in IDLE and no timeUp.
- `running` and `lowTime` are registered and consistent with state/remain in the same cycle.

Optional Feature:
- Macro: COUNTDOWN_WARN_BLINK_EN.
- Defined:
  - blinkOn toggles on every accepted `secPassed` tick while lowTime=1.
  - blinkOn is forced to 1 when lowTime=0 and in EXPIRED.
  - blinkOn resets to 1.
- Undefined: blinkOn is tied to constant 1 and no toggle register is built.

Test Plan:
- Reset, then `start`, then 3 ticks -> remain 117; digits 1,5,7; running=1; timeUp=0.
- Defaults with START_SECONDS=2, `start`, 2 ticks -> timeUp high exactly 1 cycle after the 2nd tick; state EXPIRED; digits 0,0,0. A 3rd tick gives no change and no second timeUp.
- Tick + `addTime` in the same cycle at remain=1 -> remain=10, no timeUp. Separately, `addTime` at remain=595 -> 599 (9:59).
- `pause`=1 for 5 ticks at remain=60 -> remain stays 60 (1:00), running=0. Release `pause`, then 1 tick -> 59 (0:59).
- `start` + tick in the same cycle at remain=30 -> remain=120, RUNNING. Then `resetN`=0 for 1 cycle mid-run -> IDLE, remain=120, timeUp=0.
- With COUNTDOWN_WARN_BLINK_EN: ticks from 12 down to 8 -> lowTime rises at 10. blinkOn sequence is 1,1,0,1,0 across the ticks landing on 11,10,9,8. Without the macro, blinkOn stays constant 1.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control and HUD-digit bundle for countdown_timer.
// master: drives the tick/control pulses and reads the digits and flags.
// slave : the timer itself.
interface countdown_timer_if;
   logic       secPassed;
   logic       start;
   logic       pause;
   logic       addTime;
   logic [3:0] minutes;
   logic [3:0] secTens;
   logic [3:0] secOnes;
   logic       running;
   logic       lowTime;
   logic       timeUp;
   logic       blinkOn;

   modport master (
      output secPassed, start, pause, addTime,
      input  minutes, secTens, secOnes, running, lowTime, timeUp, blinkOn
   );

   modport slave (
      input  secPassed, start, pause, addTime,
      output minutes, secTens, secOnes, running, lowTime, timeUp, blinkOn
   );
endinterface

// File: rtl/countdown_timer.sv
// Game countdown timer: holds the remaining seconds, counts down on the
// one-cycle seconds tick, shows the time as M:SS BCD digits and pulses
// timeUp once on expiry. Supports bonus time, restart and pause.
//
// Optional: define COUNTDOWN_WARN_BLINK_EN to make blinkOn toggle on each
// accepted tick while the low-time warning is active. Without it blinkOn
// is a constant 1.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset; waiting for start, ticks/bonus ignored
// RUNNING | counting down on each accepted tick
// PAUSED  | ticks ignored, bonus still accepted
// EXPIRED | remain held at 0 until the next start
module countdown_timer #(
   parameter int unsigned START_SECONDS = 120,
   parameter int unsigned BONUS_SECONDS = 10,
   parameter int unsigned WARN_SECONDS  = 10
) (
   input logic               clk,
   input logic               resetN,
   countdown_timer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

   localparam logic [9:0]  START_V = 10'(START_SECONDS);
   localparam logic [9:0]  WARN_V  = 10'(WARN_SECONDS);
   localparam logic [9:0]  MAX_V   = 10'd599;
   localparam logic [10:0] BONUS_V = 11'(BONUS_SECONDS);

   state_t      state, state_n;
   logic [9:0]  remain, remain_n;
   logic [10:0] bonus_sum;
   logic [9:0]  with_bonus;
   logic        running_q, running_n;
   logic        low_q, low_n;
   logic        time_up_q, time_up_n;

   // Next state, next count and the registered status flags.
   always_comb begin
      state_n   = state;
      remain_n  = remain;
      time_up_n = 1'b0;
      // Saturate the bonus first so a same-cycle tick decrements from 599.
      bonus_sum  = {1'b0, remain} + BONUS_V;
      with_bonus = remain;
      if (bus.addTime) begin
         with_bonus = (bonus_sum > {1'b0, MAX_V}) ? MAX_V : bonus_sum[9:0];
      end

      if (bus.start) begin
         remain_n = START_V;
         state_n  = bus.pause ? PAUSED : RUNNING;
      end else begin
         case (state)
            RUNNING: begin
               remain_n = with_bonus;
               if (bus.pause) begin
                  state_n = PAUSED;
               end else if (bus.secPassed) begin
                  remain_n = with_bonus - 10'd1;
                  if (with_bonus == 10'd1) begin
                     state_n   = EXPIRED;
                     time_up_n = 1'b1;
                  end
               end
            end
            PAUSED: begin
               remain_n = with_bonus;
               if (!bus.pause) state_n = RUNNING;
            end
            default: ;
         endcase
      end

      running_n = (state_n == RUNNING);
      low_n     = ((state_n == RUNNING) || (state_n == PAUSED)) &&
                  (remain_n != 10'd0) && (remain_n <= WARN_V);
   end

   // State, counter and flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state     <= IDLE;
         remain    <= START_V;
         running_q <= 1'b0;
         low_q     <= 1'b0;
         time_up_q <= 1'b0;
      end else begin
         state     <= state_n;
         remain    <= remain_n;
         running_q <= running_n;
         low_q     <= low_n;
         time_up_q <= time_up_n;
      end
   end

`ifdef COUNTDOWN_WARN_BLINK_EN
   logic blink_q;
   logic tick_taken;

   assign tick_taken = bus.secPassed && !bus.start && !bus.pause && (state == RUNNING);

   // Blink phase flips on each counted tick inside the warning window.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         blink_q <= 1'b1;
      end else if (!low_n) begin
         blink_q <= 1'b1;
      end else if (tick_taken) begin
         blink_q <= ~blink_q;
      end
   end

   assign bus.blinkOn = blink_q;
`else
   assign bus.blinkOn = 1'b1;
`endif

   assign bus.minutes = 4'(remain / 10'd60);
   assign bus.secTens = 4'((remain % 10'd60) / 10'd10);
   assign bus.secOnes = 4'(remain % 10'd10);
   assign bus.running = running_q;
   assign bus.lowTime = low_q;
   assign bus.timeUp  = time_up_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed vector table, hand sequences for the
// multi-cycle corners, then random stimulus against a behavioural model.
module tb_countdown_timer;
   localparam int START = 120;
   localparam int BONUS = 10;
   localparam int WARN  = 10;
   localparam int MAXS  = 599;

   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

   logic clk = 1'b0;
   logic resetN;
   countdown_timer_if bus ();

   countdown_timer dut (.clk(clk), .resetN(resetN), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int m_state, m_remain;
   bit m_tu, m_low, m_blink;

   typedef struct {
      logic rst_n, tick, st, pa, add;
      int   remain;
      logic run, low, tu;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic model_step(input logic r, t, s, p, a);
      bit counted;
      counted = 0;
      if (!r) begin
         m_state = M_IDLE; m_remain = START; m_tu = 0; m_blink = 1;
      end else begin
         m_tu = 0;
         if (s) begin
            m_remain = START;
            m_state  = p ? M_PAUSE : M_RUN;
         end else if (m_state == M_RUN || m_state == M_PAUSE) begin
            if (a) m_remain = (m_remain + BONUS > MAXS) ? MAXS : m_remain + BONUS;
            if (m_state == M_PAUSE) begin
               if (!p) m_state = M_RUN;
            end else if (p) begin
               m_state = M_PAUSE;
            end else if (t) begin
               counted  = 1;
               m_remain = m_remain - 1;
               if (m_remain == 0) begin
                  m_state = M_EXP;
                  m_tu    = 1;
               end
            end
         end
      end
      m_low = (m_state == M_RUN || m_state == M_PAUSE) && m_remain >= 1 && m_remain <= WARN;
`ifdef COUNTDOWN_WARN_BLINK_EN
      if (!r || !m_low) m_blink = 1;
      else if (counted) m_blink = !m_blink;
`else
      m_blink = 1;
`endif
   endtask

   task automatic check_time(input string name, input int secs);
      chk({name, ".minutes"}, int'(bus.minutes), secs / 60);
      chk({name, ".secTens"}, int'(bus.secTens), (secs % 60) / 10);
      chk({name, ".secOnes"}, int'(bus.secOnes), secs % 10);
   endtask

   task automatic check_model();
      check_time("model", m_remain);
      chk("model.running", int'(bus.running), int'(m_state == M_RUN));
      chk("model.lowTime", int'(bus.lowTime), int'(m_low));
      chk("model.timeUp", int'(bus.timeUp), int'(m_tu));
      chk("model.blinkOn", int'(bus.blinkOn), int'(m_blink));
   endtask

   task automatic cycle(input logic r, t, s, p, a);
      resetN        = r;
      bus.secPassed = t;
      bus.start     = s;
      bus.pause     = p;
      bus.addTime   = a;
      @(posedge clk);
      model_step(r, t, s, p, a);
      #1;
      check_model();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, 0);
   endtask

   initial begin
      // rst_n tick start pause add | remain run low tu
      tbl[0]  = '{0, 0, 0, 0, 0, 120, 0, 0, 0};
      tbl[1]  = '{1, 0, 1, 0, 0, 120, 1, 0, 0};
      tbl[2]  = '{1, 1, 0, 0, 0, 119, 1, 0, 0};
      tbl[3]  = '{1, 1, 0, 0, 0, 118, 1, 0, 0};
      tbl[4]  = '{1, 1, 0, 0, 0, 117, 1, 0, 0};
      tbl[5]  = '{1, 0, 0, 0, 1, 127, 1, 0, 0};
      tbl[6]  = '{1, 1, 0, 1, 0, 127, 0, 0, 0};
      tbl[7]  = '{1, 1, 0, 1, 0, 127, 0, 0, 0};
      tbl[8]  = '{1, 0, 0, 1, 1, 137, 0, 0, 0};
      tbl[9]  = '{1, 1, 0, 0, 0, 137, 1, 0, 0};
      tbl[10] = '{1, 1, 0, 0, 0, 136, 1, 0, 0};
      tbl[11] = '{1, 1, 1, 0, 0, 120, 1, 0, 0};
      tbl[12] = '{1, 0, 1, 1, 0, 120, 0, 0, 0};
      tbl[13] = '{1, 0, 0, 0, 0, 120, 1, 0, 0};
      tbl[14] = '{1, 1, 0, 0, 1, 129, 1, 0, 0};
      tbl[15] = '{0, 1, 0, 0, 0, 120, 0, 0, 0};
      tbl[16] = '{1, 1, 0, 0, 0, 120, 0, 0, 0};
      tbl[17] = '{1, 0, 0, 0, 1, 120, 0, 0, 0};

      resetN = 1'b0;
      bus.secPassed = 0; bus.start = 0; bus.pause = 0; bus.addTime = 0;
      m_state = M_IDLE; m_remain = START; m_tu = 0; m_low = 0; m_blink = 1;

      for (int i = 0; i < 18; i++) begin
         cycle(tbl[i].rst_n, tbl[i].tick, tbl[i].st, tbl[i].pa, tbl[i].add);
         check_time($sformatf("tbl%0d", i), tbl[i].remain);
         chk($sformatf("tbl%0d.running", i), int'(bus.running), int'(tbl[i].run));
         chk($sformatf("tbl%0d.lowTime", i), int'(bus.lowTime), int'(tbl[i].low));
         chk($sformatf("tbl%0d.timeUp", i), int'(bus.timeUp), int'(tbl[i].tu));
         chk($sformatf("tbl%0d.blinkOn", i), int'(bus.blinkOn), 1);
      end

      // Expiry: timeUp exactly one cycle, then nothing moves.
      cycle(1, 0, 1, 0, 0);
      ticks(119);
      check_time("exp.at1", 1);
      chk("exp.low_at1", int'(bus.lowTime), 1);
      cycle(1, 1, 0, 0, 0);
      check_time("exp.zero", 0);
      chk("exp.timeUp", int'(bus.timeUp), 1);
      chk("exp.running", int'(bus.running), 0);
      chk("exp.lowTime", int'(bus.lowTime), 0);
      cycle(1, 0, 0, 0, 0);
      chk("exp.timeUp_once", int'(bus.timeUp), 0);
      cycle(1, 1, 0, 0, 0);
      chk("exp.tick_no_tu", int'(bus.timeUp), 0);
      check_time("exp.hold", 0);
      cycle(1, 0, 0, 0, 1);
      check_time("exp.add_ignored", 0);

      // Tick plus bonus at remain=1: no expiry.
      cycle(1, 0, 1, 0, 0);
      ticks(119);
      cycle(1, 1, 0, 0, 1);
      check_time("bonus_at1", 10);
      chk("bonus_at1.timeUp", int'(bus.timeUp), 0);
      chk("bonus_at1.running", int'(bus.running), 1);

      // Saturation at 599.
      cycle(1, 0, 1, 0, 0);
      ticks(5);
      for (int i = 0; i < 48; i++) cycle(1, 0, 0, 0, 1);
      check_time("sat.595", 595);
      cycle(1, 0, 0, 0, 1);
      check_time("sat.599", 599);
      cycle(1, 0, 0, 0, 1);
      check_time("sat.hold", 599);
      cycle(1, 1, 0, 0, 1);
      check_time("sat.tick", 598);

      // Pause at 60 for five ticks.
      cycle(1, 0, 1, 0, 0);
      ticks(60);
      for (int i = 0; i < 5; i++) cycle(1, 1, 0, 1, 0);
      check_time("pause.hold", 60);
      chk("pause.running", int'(bus.running), 0);
      cycle(1, 0, 0, 0, 0);
      chk("pause.release", int'(bus.running), 1);
      cycle(1, 1, 0, 0, 0);
      check_time("pause.tick", 59);

      // Start with a same-cycle tick at 30, then reset mid-run.
      cycle(1, 0, 1, 0, 0);
      ticks(90);
      check_time("restart.at30", 30);
      cycle(1, 1, 1, 0, 0);
      check_time("restart.reload", 120);
      chk("restart.running", int'(bus.running), 1);
      ticks(3);
      cycle(0, 1, 0, 0, 0);
      check_time("midreset", 120);
      chk("midreset.running", int'(bus.running), 0);
      chk("midreset.timeUp", int'(bus.timeUp), 0);

      // Warning window and blink phase from 12 down to 8.
      cycle(1, 0, 1, 0, 0);
      ticks(108);
      check_time("warn.12", 12);
      chk("warn.low12", int'(bus.lowTime), 0);
      chk("warn.blink12", int'(bus.blinkOn), 1);
      for (int i = 0; i < 4; i++) begin
         cycle(1, 1, 0, 0, 0);
         chk($sformatf("warn.low%0d", 11 - i), int'(bus.lowTime), (11 - i <= 10) ? 1 : 0);
`ifdef COUNTDOWN_WARN_BLINK_EN
         chk($sformatf("warn.blink%0d", 11 - i), int'(bus.blinkOn), (i == 0 || i == 2) ? 1 : 0);
`else
         chk($sformatf("warn.blink%0d", 11 - i), int'(bus.blinkOn), 1);
`endif
      end

      // Random traffic against the model.
      begin
         logic p;
         p = 0;
         for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(15) == 0) p = ~p;
            cycle(($urandom_range(199) != 0),
                  ($urandom_range(2) == 0),
                  ($urandom_range(39) == 0),
                  p,
                  ($urandom_range(11) == 0));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
